// File: rtl/recip_pkg.sv
// -----------------------------------------------------------------------------
// recip_pkg
// Shared definitions for the reciprocal datapath: default widths, the FSM state
// type of the reciprocal-multiply divider and the all-ones encoding the
// reciprocal stage emits for a zero divisor.
// Ports: none (package).
// -----------------------------------------------------------------------------
package recip_pkg;

   localparam int unsigned RECIP_W     = 27;  // dividend / reciprocal / quotient width
   localparam int unsigned RECIP_FRAC  = 26;  // fractional bits of the reciprocal
   localparam int unsigned RECIP_CNT_W = 6;   // iteration counter width, 2^CNT_W > W

   // Zero-divisor encoding shared with the reciprocal stage.
   localparam logic [RECIP_W-1:0] RECIP_ALL_ONES = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } recip_state_e;

endpackage

// File: rtl/shift_add_mul_step.sv
// -----------------------------------------------------------------------------
// shift_add_mul_step
// Combinational single iteration of an unsigned shift-add multiplier:
// conditionally adds the multiplicand into the accumulator on multiplier[0],
// then shifts the multiplicand left and the multiplier right by one.
// Ports:
//   i_acc    [2W-1:0]  accumulator in
//   i_mcand  [2W-1:0]  multiplicand in
//   i_mplier [W-1:0]   multiplier in
//   o_acc    [2W-1:0]  accumulator after this iteration
//   o_mcand  [2W-1:0]  multiplicand << 1
//   o_mplier [W-1:0]   multiplier >> 1
// -----------------------------------------------------------------------------
module shift_add_mul_step
   import recip_pkg::*;
#(
   parameter int unsigned W = RECIP_W
) (
   input  logic [2*W-1:0] i_acc,
   input  logic [2*W-1:0] i_mcand,
   input  logic [W-1:0]   i_mplier,
   output logic [2*W-1:0] o_acc,
   output logic [2*W-1:0] o_mcand,
   output logic [W-1:0]   o_mplier
);

   assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
   assign o_mcand  = i_mcand << 1;
   assign o_mplier = i_mplier >> 1;

endmodule

// File: rtl/recip_mul_divide.sv
// -----------------------------------------------------------------------------
// recip_mul_divide
// Computes quotient = dividend * recip >> FRAC, where recip = floor(2^FRAC /
// divisor) comes from the upstream reciprocal stage. The product is formed by
// an iterative shift-add multiplier (one multiplier bit per cycle, W cycles).
// Results above 2^W-1 saturate to all-ones with o_sat; a zero divisor flagged
// by i_recip_zero bypasses the multiplier and returns all-ones with o_div_zero.
//
// Build option: define RECIP_MUL_ROUND_EN to round half-up (adds 2^(FRAC-1)
// before the shift); otherwise the quotient is truncated. Latency is the same.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_in_valid/o_in_ready   operand handshake (ready only when idle)
//   i_dividend [W-1:0]  unsigned dividend
//   i_recip    [W-1:0]  unsigned reciprocal, Q(W-FRAC).FRAC
//   i_recip_zero        divisor was zero
//   o_out_valid/i_out_ready result handshake
//   o_quotient [W-1:0]  unsigned result, held while o_out_valid & !i_out_ready
//   o_sat               result saturated
//   o_div_zero          result produced from i_recip_zero
// -----------------------------------------------------------------------------
module recip_mul_divide
   import recip_pkg::*;
#(
   parameter int unsigned W     = RECIP_W,
   parameter int unsigned FRAC  = RECIP_FRAC,
   parameter int unsigned CNT_W = RECIP_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_recip,
   input  logic         i_recip_zero,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [W-1:0] o_quotient,
   output logic         o_sat,
   output logic         o_div_zero
);

   localparam int unsigned PW = 2 * W;      // full product width
   localparam int unsigned SW = PW - FRAC;  // width of product >> FRAC

   localparam logic [W-1:0] ALL_ONES = '1;

`ifdef RECIP_MUL_ROUND_EN
   localparam logic [PW-1:0] ROUND_ADD = PW'(1) << (FRAC - 1);
`else
   localparam logic [PW-1:0] ROUND_ADD = '0;
`endif

   recip_state_e   r_state, w_state_nxt;
   logic [PW-1:0]  r_acc, w_acc_nxt;
   logic [PW-1:0]  r_mcand, w_mcand_nxt;
   logic [W-1:0]   r_mplier, w_mplier_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [W-1:0]   r_quotient, w_quotient_nxt;
   logic           r_sat, w_sat_nxt;
   logic           r_div_zero, w_div_zero_nxt;

   logic [PW-1:0]  w_step_acc;
   logic [PW-1:0]  w_step_mcand;
   logic [W-1:0]   w_step_mplier;
   logic [PW-1:0]  w_prod;
   logic [SW-1:0]  w_shifted;
   logic           w_ovf;

   shift_add_mul_step #(
      .W (W)
   ) u_step (
      .i_acc    (r_acc),
      .i_mcand  (r_mcand),
      .i_mplier (r_mplier),
      .o_acc    (w_step_acc),
      .o_mcand  (w_step_mcand),
      .o_mplier (w_step_mplier)
   );

   // The final partial sum is folded in on the last MUL edge, so the result is
   // taken from the step output rather than the accumulator register.
   assign w_prod    = w_step_acc + ROUND_ADD;
   assign w_shifted = SW'(w_prod >> FRAC);
   assign w_ovf     = |w_shifted[SW-1:W];

   always_comb begin
      w_state_nxt    = r_state;
      w_acc_nxt      = r_acc;
      w_mcand_nxt    = r_mcand;
      w_mplier_nxt   = r_mplier;
      w_cnt_nxt      = r_cnt;
      w_quotient_nxt = r_quotient;
      w_sat_nxt      = r_sat;
      w_div_zero_nxt = r_div_zero;

      unique case (r_state)
         IDLE: begin
            if (i_in_valid) begin
               if (i_recip_zero) begin
                  w_quotient_nxt = ALL_ONES;
                  w_sat_nxt      = 1'b0;
                  w_div_zero_nxt = 1'b1;
                  w_state_nxt    = DONE;
               end else begin
                  w_acc_nxt    = '0;
                  w_mcand_nxt  = {{W{1'b0}}, i_dividend};
                  w_mplier_nxt = i_recip;
                  w_cnt_nxt    = '0;
                  w_state_nxt  = MUL;
               end
            end
         end
         MUL: begin
            w_acc_nxt    = w_step_acc;
            w_mcand_nxt  = w_step_mcand;
            w_mplier_nxt = w_step_mplier;
            w_cnt_nxt    = r_cnt + 1'b1;
            if (r_cnt == CNT_W'(W - 1)) begin
               w_div_zero_nxt = 1'b0;
               w_state_nxt    = DONE;
               if (w_ovf) begin
                  w_quotient_nxt = ALL_ONES;
                  w_sat_nxt      = 1'b1;
               end else begin
                  w_quotient_nxt = w_shifted[W-1:0];
                  w_sat_nxt      = 1'b0;
               end
            end
         end
         DONE: begin
            if (i_out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_cnt      <= '0;
         r_quotient <= '0;
         r_sat      <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_acc      <= w_acc_nxt;
         r_mcand    <= w_mcand_nxt;
         r_mplier   <= w_mplier_nxt;
         r_cnt      <= w_cnt_nxt;
         r_quotient <= w_quotient_nxt;
         r_sat      <= w_sat_nxt;
         r_div_zero <= w_div_zero_nxt;
      end
   end

   assign o_in_ready  = (r_state == IDLE);
   assign o_out_valid = (r_state == DONE);
   assign o_quotient  = r_quotient;
   assign o_sat       = r_sat;
   assign o_div_zero  = r_div_zero;

endmodule
